// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared definitions for the ADC conversion arbiter:
//                channel-select field width and the transaction FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    // Width of one requester's channel-select field and of adc_ch_sel.
    localparam int CH_W = 3;

    // Transaction FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin picker. The search starts
//                at index (last+1) mod NREQ and wraps; the first active
//                request found wins.
//  Ports       : req    - request vector
//                last   - index of the previous winner
//                winner - one-hot winner (zero when no request)
//                valid  - at least one request active
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int LW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [LW-1:0] w_idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_idx = LW'((int'(last) + off) % NREQ);
            if (!valid && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adc_conv_arbiter
//  Description : Shares one ADC converter between NREQ requesters. A winner
//                is picked round-robin, its channel is driven to the mux, the
//                mux is allowed to settle, then SoC is held until a rising
//                edge of EoC (or a timeout). Completion is signalled with a
//                one-cycle done pulse to the owner and a registered result.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                en                  - block enable (0 aborts a transaction)
//                settle, timeout     - settle cycles, SoC-to-EoC limit (0=off)
//                req, req_ch         - per-requester request and channel
//                gnt, done, err      - owner, completion pulse, timeout pulse
//                rdata, busy         - conversion result, transaction active
//                adc_ch_sel, adc_soc - converter channel and start level
//                adc_eoc, adc_data   - converter end-of-conversion and result
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_conv_arbiter
    import adc_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 10,
    parameter int TW   = 16,
    parameter int SW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [SW-1:0]        settle,
    input  logic [TW-1:0]        timeout,
    input  logic [NREQ-1:0]      req,
    input  logic [CH_W*NREQ-1:0] req_ch,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic [CH_W-1:0]      adc_ch_sel,
    output logic                 adc_soc,
    input  logic                 adc_eoc,
    input  logic [DW-1:0]        adc_data
);

    localparam int            LW          = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LW-1:0] c_LAST_RST  = LW'(NREQ - 1);

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_done;
    logic              r_err;
    logic [DW-1:0]     r_rdata;
    logic              r_busy;
    logic [CH_W-1:0]   r_ch_sel;
    logic              r_soc;
    logic [SW-1:0]     r_scnt;
    logic [TW-1:0]     r_tcnt;
    logic [LW-1:0]     r_last;
    logic [LW-1:0]     r_owner;
    logic              r_eoc_q;

    logic [NREQ-1:0]   w_winner;
    logic              w_valid;
    logic [LW-1:0]     w_win_idx;
    logic [CH_W-1:0]   w_win_ch;
    logic              w_eoc_rise;
    logic              w_tmo;

    rr_arbiter #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_rr (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .valid  (w_valid)
    );

    // Index and channel field of the one-hot winner.
    always_comb begin
        w_win_idx = '0;
        w_win_ch  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx = LW'(i);
                w_win_ch  = req_ch[CH_W*i +: CH_W];
            end
        end
    end

    // Edge detect: an EoC that is already high when SoC starts has a high
    // history sample and so cannot complete the conversion until it cycles.
    assign w_eoc_rise = adc_eoc & ~r_eoc_q;

    // The counter starts at 0 in the first SoC cycle, so SoC stays high for
    // exactly 'timeout' cycles when no EoC edge arrives.
    assign w_tmo = (timeout != '0) && (r_tcnt == (timeout - TW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_busy   <= 1'b0;
            r_ch_sel <= '0;
            r_soc    <= 1'b0;
            r_scnt   <= '0;
            r_tcnt   <= '0;
            r_last   <= c_LAST_RST;
            r_owner  <= '0;
            r_eoc_q  <= 1'b0;
        end else begin
            r_eoc_q <= adc_eoc;
            r_done  <= '0;
            r_err   <= 1'b0;

            if (!en && (r_state != ST_IDLE)) begin
                // Abort: drop everything silently, fairness pointer untouched.
                r_state <= ST_IDLE;
                r_gnt   <= '0;
                r_soc   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (en && w_valid) begin
                            r_gnt    <= w_winner;
                            r_owner  <= w_win_idx;
                            r_ch_sel <= w_win_ch;
                            r_scnt   <= settle;
                            r_busy   <= 1'b1;
                            r_state  <= ST_SETTLE;
                        end
                    end

                    ST_SETTLE: begin
                        if (r_scnt == '0) begin
                            r_soc   <= 1'b1;
                            r_tcnt  <= '0;
                            r_state <= ST_START;
                        end else begin
                            r_scnt <= r_scnt - SW'(1);
                        end
                    end

                    ST_START, ST_WAIT: begin
                        if (w_eoc_rise) begin
                            r_soc   <= 1'b0;
                            r_rdata <= adc_data;
                            r_done  <= r_gnt;
                            r_state <= ST_DONE;
                        end else if (w_tmo) begin
                            r_soc   <= 1'b0;
                            r_done  <= r_gnt;
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_tcnt  <= r_tcnt + TW'(1);
                            r_state <= ST_WAIT;
                        end
                    end

                    ST_DONE: begin
                        r_last  <= r_owner;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign busy       = r_busy;
    assign adc_ch_sel = r_ch_sel;
    assign adc_soc    = r_soc;

endmodule
`default_nettype wire

// File: doc/adc_conv_arbiter.md
ADC_CONV_ARBITER -- requirements
Module: adc_conv_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; DW, default 10, conversion result width; TW, default 16, timeout counter width; SW, default 4, settle counter width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all logic posedge clk
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  block enable
- settle  in  SW  channel-mux settle cycles before SoC
- timeout  in  TW  max clk cycles from SoC assert to EoC; 0 = no timeout
- req  in  NREQ  per-requester conversion request, level
- req_ch  in  3*NREQ  channel for requester i at [3i+2:3i]
- gnt  out  NREQ  one-hot owner of current transaction
- done  out  NREQ  one-cycle completion pulse to owner
- err  out  1  one-cycle timeout pulse, coincident with done
- rdata  out  DW  registered result, valid with done, held until next done
- busy  out  1  transaction in progress (state != IDLE)
- adc_ch_sel  out  3  channel select to converter
- adc_soc  out  1  start-of-conversion level to converter
- adc_eoc  in  1  converter end-of-conversion level (multi-cycle high)
- adc_data  in  DW  converter result, valid while adc_eoc high

Function
REQ-003 FSM states SHALL be IDLE, SETTLE, START, WAIT, DONE.
REQ-004 IDLE: when en=1 and req!=0, winner SHALL be picked round-robin starting at index (last_winner+1) mod NREQ; gnt, adc_ch_sel latched next cycle; go SETTLE.
REQ-005 After reset, last_winner SHALL be NREQ-1, so requester 0 has top priority.
REQ-006 SETTLE: counter loads settle, decrements each cycle; at 0 go START (settle=0 -> one cycle in SETTLE).
REQ-007 START: adc_soc=1; SHALL hold adc_soc until adc_eoc rising edge (adc_eoc=1 with previous-cycle sample 0).
REQ-008 An adc_eoc already high on entry to START SHALL be ignored until it falls and rises again.
REQ-009 On eoc rising edge: adc_soc=0, rdata<=adc_data, go DONE.
REQ-010 DONE: done[owner]=1 for exactly one cycle; last_winner<=owner; gnt cleared; return IDLE; next grant no earlier than the cycle after DONE.
REQ-011 Timeout: counter starts at 0 on entering START, increments each cycle; if timeout!=0 and count reaches timeout before eoc edge -> adc_soc=0, rdata unchanged, go DONE with err=1.
REQ-012 req deasserted by owner after grant SHALL NOT abort the transaction; done still issued.
REQ-013 req_ch changes after grant SHALL NOT affect adc_ch_sel for that transaction.
REQ-014 en=0 in any non-IDLE state SHALL abort: next cycle IDLE, gnt=0, adc_soc=0, no done, no err, last_winner unchanged.
REQ-015 gnt SHALL be one-hot or zero at all times; done only to the granted index.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 rst_n low SHALL asynchronously force: state IDLE, gnt=0, done=0, err=0, rdata=0, busy=0, adc_ch_sel=0, adc_soc=0, counters 0, last_winner=NREQ-1, eoc history=0.
REQ-018 Reset mid-transaction SHALL discard it; no done after release.

Structure
REQ-019 FSM state encodings and channel-field width (3) SHALL live in shared package adc_pkg.
REQ-020 Round-robin picker SHALL be a sub-module rr_arbiter (inputs req, last; output one-hot winner, valid), purely combinational.

Verification
REQ-021 req=4'b0001, settle=2, eoc rises 5 cycles after SoC with adc_data=10'h2A5 -> adc_ch_sel=req_ch[2:0] before adc_soc, done[0] one cycle, rdata=10'h2A5.
REQ-022 req=4'b1111 held -> grants in order 0,1,2,3,0, each one full transaction.
REQ-023 timeout=8, adc_eoc stuck 0 -> adc_soc drops after 8 cycles, done[owner]=1 with err=1, rdata unchanged.
REQ-024 adc_eoc already 1 entering START, falls, rises 3 cycles later -> completion only on the second edge.
REQ-025 en dropped in WAIT -> IDLE next cycle, no done; then en=1 with req=4'b0010 -> grant to 1, correct completion.
REQ-026 rst_n asserted in WAIT -> all outputs 0 immediately; after release requester 0 wins first.
